flit_ejector: RTL and testbench
===============================

FLIT_EJECTOR -- requirements
Module: flit_ejector

Interface
REQ-001 Parameter DEPTH, default 4, sets the receive FIFO depth in flits (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 local_id  in  5  this node's number.
REQ-005 i_flit  in  73  router eject flit: [72] valid, [71:70] type (00 head, 01 body, 10 tail, 11 single), [69:65] dst node, [64] reserved, [63:0] payload.
REQ-006 o_credit_valid  out  1  one-cycle credit-return pulse to the router.
REQ-007 o_credit  out  3  credit count returned; 3'd1 when o_credit_valid is high, else 3'd0.
REQ-008 o_req_rx  out  1  data-ready request to the PE.
REQ-009 i_ack_rx  in  1  PE acknowledge of the current word.
REQ-010 o_data  out  64  delivered data word.
REQ-011 o_src  out  8  packet source, from the head flit.
REQ-012 o_id  out  6  packet id, from the head flit.
REQ-013 o_seq_len  out  6  packet sequence length, from the head flit.
REQ-014 o_last  out  1  o_data is the final word of its packet.
REQ-015 o_overflow  out  1  sticky flag: a flit was dropped on a full FIFO.
REQ-016 o_drop_cnt  out  8  count of discarded packets and stray flits; saturates at 255.

Function
REQ-017 FIFO write:
- A flit with i_flit[72]=1 SHALL be written when the FIFO is not full; bits [71:0] are stored.
- Fullness is judged on the pre-pop count, so a same-cycle pop does not admit a write.
REQ-018 Valid flit while full: flit discarded, o_overflow set to 1 until reset, no credit returned.
REQ-019 Credit return: each FIFO pop SHALL produce exactly one o_credit_valid pulse with o_credit=3'd1, registered on the edge after the pop.
REQ-020 FSM states: IDLE, BODY, DELIVER, DROP.
REQ-021 IDLE, front flit = head:
- dst == local_id: latch o_src=payload[63:56], o_seq_len=payload[47:42], o_id=payload[41:36]; pop; go BODY.
- dst mismatch: pop; increment o_drop_cnt; go DROP.
REQ-022 IDLE, front flit = single, dst match: latch header fields as for head; o_data={32'd0, payload[31:0]}; o_last=1; pop; go DELIVER. Dst mismatch: pop; increment o_drop_cnt; stay IDLE.
REQ-023 IDLE, front flit = body or tail: pop; increment o_drop_cnt; stay IDLE.
REQ-024 BODY, front flit = body or tail: o_data=payload; o_last=(type==tail); pop; go DELIVER.
REQ-025 BODY, front flit = head or single (truncated packet): no pop; increment o_drop_cnt; go IDLE.
REQ-026 DELIVER:
- o_req_rx=1; o_data, o_last and header outputs held stable.
- On a cycle with i_ack_rx=1: o_req_rx drops on the next edge; go IDLE if o_last, else BODY.
REQ-027 DROP: pop one flit per cycle while non-empty; return to IDLE after popping a tail or single.
REQ-028 Latency: a body flit written at edge t into an empty FIFO, with the FSM in BODY, SHALL give o_req_rx=1 after edge t+1.
REQ-029 FIFO pointers wrap modulo DEPTH; empty/full are derived from a count of width log2(DEPTH)+1.
REQ-030 FSM pops at most one flit per cycle; o_drop_cnt increments at most once per cycle.

Reset
REQ-031 While rst=1:
- FIFO emptied; FSM set to IDLE.
- All outputs 0; o_overflow and o_drop_cnt cleared.
- Writes, pops and credit pulses suppressed, including mid-packet and mid-handshake.

Structure
REQ-032 Shared package SHALL hold the flit-type encodings, the flit field bit positions, and the 73-bit flit width.
REQ-033 The FIFO SHALL be one sub-module, flit_fifo, parameterised by DEPTH and WIDTH=72.

Verification
REQ-034 Head (dst=local_id=5, src=8'h12, id=3, seq_len=2), body 64'hA, tail 64'hB, PE ack immediate -> two deliveries: A with o_last=0, then B with o_last=1; o_src=8'h12; three credit pulses.
REQ-035 Head dst=7, local_id=5, followed by body and tail -> no o_req_rx; o_drop_cnt=1; three credits.
REQ-036 PE holds i_ack_rx=0 while 6 valid flits arrive back-to-back, DEPTH=4 -> o_overflow=1; exactly 4 credits once the FIFO drains.
REQ-037 Single flit with payload[31:0]=32'h40200000 -> o_data=64'h0000000040200000, o_last=1, one credit.
REQ-038 rst pulsed while in DELIVER -> next cycle o_req_rx=0, FIFO empty, FSM in IDLE, o_drop_cnt=0.
REQ-039 Head, then a new head with no tail -> o_drop_cnt=1; second packet delivered correctly.

Source files
------------

// File: rtl/flit_ejector_pkg.sv
// Shared flit layout and encodings for the flit ejector and its receive FIFO.
package flit_ejector_pkg;

  localparam int unsigned FLIT_W    = 73;
  localparam int unsigned FIFO_W    = 72;

  localparam int unsigned F_VALID   = 72;
  localparam int unsigned F_TYPE_HI = 71;
  localparam int unsigned F_TYPE_LO = 70;
  localparam int unsigned F_DST_HI  = 69;
  localparam int unsigned F_DST_LO  = 65;
  localparam int unsigned F_PAY_HI  = 63;
  localparam int unsigned F_PAY_LO  = 0;

  // Header fields carried in the payload of head/single flits
  localparam int unsigned H_SRC_HI  = 63;
  localparam int unsigned H_SRC_LO  = 56;
  localparam int unsigned H_LEN_HI  = 47;
  localparam int unsigned H_LEN_LO  = 42;
  localparam int unsigned H_ID_HI   = 41;
  localparam int unsigned H_ID_LO   = 36;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_DELIVER,
    ST_DROP
  } ej_state_e;

endpackage

// File: rtl/flit_ejector_fifo.sv
// Receive FIFO (module flit_fifo): first-word fall-through, write gated on the pre-pop fullness.
module flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign push      = wr_en_i & ~full_o & ~rst;
  assign pop       = rd_en_i & ~empty_o & ~rst;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/flit_ejector.sv
// Network ejection port: buffers router flits, filters by destination and
// hands packet words to the PE with a req/ack handshake, returning one credit per pop.
module flit_ejector
  import flit_ejector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        local_id,
  input  logic [FLIT_W-1:0] i_flit,
  output logic              o_credit_valid,
  output logic [2:0]        o_credit,
  output logic              o_req_rx,
  input  logic              i_ack_rx,
  output logic [63:0]       o_data,
  output logic [7:0]        o_src,
  output logic [5:0]        o_id,
  output logic [5:0]        o_seq_len,
  output logic              o_last,
  output logic              o_overflow,
  output logic [7:0]        o_drop_cnt
);

  logic              fifo_empty, fifo_full;
  logic [FIFO_W-1:0] front;
  flit_type_e        front_type;
  logic              dst_match;
  logic [63:0]       payload;

  ej_state_e state_q, state_d;
  logic      pop, drop_inc, ld_hdr, ld_single, ld_body;

  logic [63:0] data_q;
  logic [7:0]  src_q;
  logic [5:0]  id_q, seq_len_q;
  logic        last_q, credit_q, overflow_q;
  logic [7:0]  drop_cnt_q;

  flit_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (i_flit[F_VALID]),
    .wr_data_i(i_flit[FIFO_W-1:0]),
    .rd_en_i  (pop),
    .rd_data_o(front),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

  assign front_type = flit_type_e'(front[F_TYPE_HI:F_TYPE_LO]);
  assign dst_match  = (front[F_DST_HI:F_DST_LO] == local_id);
  assign payload    = front[F_PAY_HI:F_PAY_LO];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (front_type == FT_HEAD)                     state_d = dst_match ? ST_BODY : ST_DROP;
          else if (front_type == FT_SINGLE && dst_match) state_d = ST_DELIVER;
        end
      end
      ST_BODY: begin
        if (!fifo_empty) begin
          state_d = (front_type == FT_BODY || front_type == FT_TAIL) ? ST_DELIVER : ST_IDLE;
        end
      end
      ST_DELIVER: begin
        if (i_ack_rx) state_d = last_q ? ST_IDLE : ST_BODY;
      end
      ST_DROP: begin
        if (!fifo_empty && (front_type == FT_TAIL || front_type == FT_SINGLE)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A head/single arriving in BODY ends the current packet without being consumed
  always_comb begin
    pop       = 1'b0;
    drop_inc  = 1'b0;
    ld_hdr    = 1'b0;
    ld_single = 1'b0;
    ld_body   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (front_type == FT_HEAD || front_type == FT_SINGLE) begin
            ld_hdr    = dst_match;
            ld_single = dst_match && (front_type == FT_SINGLE);
            drop_inc  = !dst_match;
          end else begin
            drop_inc  = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (!fifo_empty) begin
          if (front_type == FT_BODY || front_type == FT_TAIL) begin
            pop     = 1'b1;
            ld_body = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_DROP:    pop = !fifo_empty;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      src_q      <= '0;
      id_q       <= '0;
      seq_len_q  <= '0;
      last_q     <= 1'b0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      credit_q <= pop;
      if (i_flit[F_VALID] && fifo_full) overflow_q <= 1'b1;
      if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (ld_hdr) begin
        src_q     <= payload[H_SRC_HI:H_SRC_LO];
        seq_len_q <= payload[H_LEN_HI:H_LEN_LO];
        id_q      <= payload[H_ID_HI:H_ID_LO];
      end
      if (ld_single) begin
        data_q <= {32'd0, payload[31:0]};
        last_q <= 1'b1;
      end
      if (ld_body) begin
        data_q <= payload;
        last_q <= (front_type == FT_TAIL);
      end
    end
  end

  assign o_credit_valid = credit_q;
  assign o_credit       = {2'b00, credit_q};
  assign o_req_rx       = (state_q == ST_DELIVER);
  assign o_data         = data_q;
  assign o_src          = src_q;
  assign o_id           = id_q;
  assign o_seq_len      = seq_len_q;
  assign o_last         = last_q;
  assign o_overflow     = overflow_q;
  assign o_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_flit_ejector.sv
// Self-checking bench for flit_ejector: directed scenarios plus a randomized
// flit stream scored against a packet-level reference model.
module tb_flit_ejector;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  local_id;
  logic [72:0] i_flit;
  logic        o_credit_valid;
  logic [2:0]  o_credit;
  logic        o_req_rx;
  logic        i_ack_rx;
  logic [63:0] o_data;
  logic [7:0]  o_src;
  logic [5:0]  o_id;
  logic [5:0]  o_seq_len;
  logic        o_last;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;

  always #5 clk = ~clk;

  flit_ejector #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .local_id      (local_id),
    .i_flit        (i_flit),
    .o_credit_valid(o_credit_valid),
    .o_credit      (o_credit),
    .o_req_rx      (o_req_rx),
    .i_ack_rx      (i_ack_rx),
    .o_data        (o_data),
    .o_src         (o_src),
    .o_id          (o_id),
    .o_seq_len     (o_seq_len),
    .o_last        (o_last),
    .o_overflow    (o_overflow),
    .o_drop_cnt    (o_drop_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  src;
    logic [5:0]  id;
    logic [5:0]  len;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    credits  = 0;
  int    sent     = 0;
  int    req_cycles = 0;
  bit    ack_rand  = 1'b0;
  logic  ack_level = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [72:0] mk(input logic [1:0] t, input logic [4:0] dst, input logic [63:0] p);
    return {1'b1, t, dst, 1'b0, p};
  endfunction

  function automatic logic [63:0] hdr(input logic [7:0] src, input logic [5:0] id, input logic [5:0] len);
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[63:56] = src;
    p[47:42] = len;
    p[41:36] = id;
    return p;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Packet-level view of an accepted flit stream: queues expected words, returns drop count
  function automatic int unsigned build_expect(input logic [72:0] fl[$], input logic [4:0] lid);
    int unsigned drops = 0;
    int unsigned i = 0;
    logic [1:0]  t;
    logic [63:0] p;
    logic [7:0]  src;
    logic [5:0]  id, len;
    word_t       w;
    while (i < fl.size()) begin
      t = fl[i][71:70];
      p = fl[i][63:0];
      if (t == 2'b01 || t == 2'b10) begin
        drops++; i++;
      end else if (fl[i][69:65] != lid) begin
        drops++; i++;
        if (t == 2'b00) begin
          while (i < fl.size()) begin
            t = fl[i][71:70]; i++;
            if (t == 2'b10 || t == 2'b11) break;
          end
        end
      end else begin
        src = p[63:56]; len = p[47:42]; id = p[41:36]; i++;
        if (t == 2'b11) begin
          w = '{data: {32'd0, p[31:0]}, last: 1'b1, src: src, id: id, len: len};
          exp_q.push_back(w);
        end else begin
          while (i < fl.size()) begin
            t = fl[i][71:70];
            if (t == 2'b00 || t == 2'b11) begin drops++; break; end
            w = '{data: fl[i][63:0], last: (t == 2'b10), src: src, id: id, len: len};
            exp_q.push_back(w);
            i++;
            if (t == 2'b10) break;
          end
        end
      end
    end
    return drops;
  endfunction

  initial begin
    i_ack_rx = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_ack_rx = ack_rand ? 1'($urandom_range(0, 1)) : ack_level;
    end
  end

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_val("credit_value", 64'(o_credit), o_credit_valid ? 64'd1 : 64'd0);
        if (o_credit_valid) credits++;
        if (o_req_rx) req_cycles++;
        if (o_req_rx && i_ack_rx) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_req", 64'(o_req_rx), 64'd0);
          end else begin
            w = exp_q.pop_front();
            check_val("data", o_data, w.data);
            check_val("last", 64'(o_last), 64'(w.last));
            check_val("src", 64'(o_src), 64'(w.src));
            check_val("id", 64'(o_id), 64'(w.id));
            check_val("seq_len", 64'(o_seq_len), 64'(w.len));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    i_flit = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", 64'(o_req_rx), 64'd0);
    check_val("rst_credit", {61'd0, o_credit_valid, o_credit[1:0]}, 64'd0);
    check_val("rst_data", o_data, 64'd0);
    check_val("rst_hdr", {42'd0, o_src, o_id, o_seq_len, o_last}, 64'd0);
    check_val("rst_flags", {55'd0, o_overflow, o_drop_cnt}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    sent = 0; credits = 0; req_cycles = 0;
  endtask

  task automatic send_flit(input logic [72:0] f);
    int unsigned c = 0;
    while ((sent - credits) >= int'(DEPTH) && c < 1000) begin
      @(posedge clk); #1; c++;
    end
    i_flit = f;
    sent++;
    @(posedge clk); #1;
    i_flit = '0;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned c = 0;
    while ((credits != sent || exp_q.size() != 0) && c < budget) begin
      @(posedge clk); #1; c++;
    end
    repeat (5) @(posedge clk);
    #1;
    check_val({tag, "_credits"}, 64'(credits), 64'(sent));
    check_val({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_req(input string tag);
    int unsigned c = 0;
    while (!o_req_rx && c < 200) begin
      @(posedge clk); #1; c++;
    end
    check_val(tag, 64'(o_req_rx), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [72:0] stream[$];
    logic [63:0] p;
    logic [4:0]  dst;
    int          base;
    int unsigned kind, nb, exp_drops;
    i_flit = '0;
    local_id = 5'd5;
    @(posedge clk); #1;
    do_reset();

    // Local packet, immediate ack
    ack_rand = 1'b0; ack_level = 1'b1;
    exp_q.push_back('{data: 64'hA, last: 1'b0, src: 8'h12, id: 6'd3, len: 6'd2});
    exp_q.push_back('{data: 64'hB, last: 1'b1, src: 8'h12, id: 6'd3, len: 6'd2});
    send_flit(mk(2'b00, 5'd5, hdr(8'h12, 6'd3, 6'd2)));
    send_flit(mk(2'b01, 5'd5, 64'hA));
    send_flit(mk(2'b10, 5'd5, 64'hB));
    drain("local_pkt", 200);
    check_val("local_pkt_ncred", 64'(credits), 64'd3);
    check_val("local_pkt_drop", 64'(o_drop_cnt), 64'd0);

    // Packet for another node
    do_reset();
    send_flit(mk(2'b00, 5'd7, hdr(8'h55, 6'd1, 6'd2)));
    send_flit(mk(2'b01, 5'd7, 64'h1));
    send_flit(mk(2'b10, 5'd7, 64'h2));
    drain("foreign", 200);
    check_val("foreign_ncred", 64'(credits), 64'd3);
    check_val("foreign_drop", 64'(o_drop_cnt), 64'd1);
    check_val("foreign_req", 64'(req_cycles), 64'd0);

    // Single flit with 32-bit payload
    do_reset();
    local_id = 5'd9;
    p = {32'hDEADBEEF, 32'h40200000};
    exp_q.push_back('{data: 64'h0000000040200000, last: 1'b1, src: p[63:56], id: p[41:36], len: p[47:42]});
    send_flit(mk(2'b11, 5'd9, p));
    drain("single", 200);
    check_val("single_ncred", 64'(credits), 64'd1);

    // Overflow: PE stalled in DELIVER while six flits arrive back-to-back
    do_reset();
    ack_level = 1'b0;
    local_id = 5'd5;
    exp_q.push_back('{data: 64'h0000000011112222, last: 1'b1, src: 8'h77, id: 6'd4, len: 6'd1});
    p = hdr(8'h77, 6'd4, 6'd1);
    p[31:0] = 32'h11112222;
    send_flit(mk(2'b11, 5'd5, p));
    wait_req("ovf_stall_req");
    base = credits;
    for (int i = 0; i < 6; i++) begin
      i_flit = mk(2'b01, 5'd5, rnd64());
      @(posedge clk); #1;
    end
    i_flit = '0;
    check_val("ovf_flag", 64'(o_overflow), 64'd1);
    ack_level = 1'b1;
    for (int c = 0; c < 100 && credits < base + 4; c++) begin
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
    check_val("ovf_ncred", 64'(credits - base), 64'd4);
    check_val("ovf_drop", 64'(o_drop_cnt), 64'd4);
    check_val("ovf_sticky", 64'(o_overflow), 64'd1);
    check_val("ovf_pending", 64'(exp_q.size()), 64'd0);
    sent = credits;

    // Reset while in DELIVER with flits still queued behind it
    ack_level = 1'b0;
    send_flit(mk(2'b11, 5'd5, hdr(8'h99, 6'd9, 6'd1)));
    send_flit(mk(2'b01, 5'd5, rnd64()));
    send_flit(mk(2'b10, 5'd5, rnd64()));
    wait_req("midrst_req");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check_val("midrst_req_low", 64'(o_req_rx), 64'd0);
    check_val("midrst_drop", 64'(o_drop_cnt), 64'd0);
    check_val("midrst_ovf", 64'(o_overflow), 64'd0);
    check_val("midrst_out", {o_data[55:0], o_last}, 57'd0);
    ack_level = 1'b1;
    base = credits;
    repeat (8) @(posedge clk);
    #1;
    check_val("midrst_fifo_empty", 64'(credits - base), 64'd0);
    check_val("midrst_drop_after", 64'(o_drop_cnt), 64'd0);
    sent = credits;
    p = hdr(8'h3C, 6'd7, 6'd1);
    exp_q.push_back('{data: {32'd0, p[31:0]}, last: 1'b1, src: 8'h3C, id: 6'd7, len: 6'd1});
    send_flit(mk(2'b11, 5'd5, p));
    drain("midrst_next", 200);

    // Truncated packet followed by a complete one
    do_reset();
    ack_rand = 1'b1;
    local_id = 5'd3;
    exp_q.push_back('{data: 64'hC, last: 1'b0, src: 8'h34, id: 6'd2, len: 6'd2});
    exp_q.push_back('{data: 64'hD, last: 1'b1, src: 8'h34, id: 6'd2, len: 6'd2});
    send_flit(mk(2'b00, 5'd3, hdr(8'h21, 6'd1, 6'd1)));
    send_flit(mk(2'b00, 5'd3, hdr(8'h34, 6'd2, 6'd2)));
    send_flit(mk(2'b01, 5'd3, 64'hC));
    send_flit(mk(2'b10, 5'd3, 64'hD));
    drain("trunc", 300);
    check_val("trunc_drop", 64'(o_drop_cnt), 64'd1);
    check_val("trunc_ncred", 64'(credits), 64'd4);

    // Randomized mixed traffic
    do_reset();
    local_id = 5'($urandom);
    stream.delete();
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      dst = ($urandom_range(0, 3) != 0) ? local_id : (local_id ^ 5'($urandom_range(1, 31)));
      case (kind)
        0, 1, 2, 3, 4: begin
          stream.push_back(mk(2'b00, dst, hdr(8'($urandom), 6'($urandom), 6'($urandom))));
          nb = $urandom_range(0, 3);
          for (int b = 0; b < int'(nb); b++) stream.push_back(mk(2'b01, dst, rnd64()));
          stream.push_back(mk(2'b10, dst, rnd64()));
        end
        5, 6: stream.push_back(mk(2'b11, dst, rnd64()));
        7:    stream.push_back(mk(2'($urandom_range(1, 2)), dst, rnd64()));
        default: begin
          stream.push_back(mk(2'b00, dst, hdr(8'($urandom), 6'($urandom), 6'($urandom))));
          nb = $urandom_range(0, 2);
          for (int b = 0; b < int'(nb); b++) stream.push_back(mk(2'b01, dst, rnd64()));
        end
      endcase
    end
    stream.push_back(mk(2'b00, local_id, hdr(8'hE1, 6'd5, 6'd2)));
    stream.push_back(mk(2'b10, local_id, rnd64()));
    exp_drops = build_expect(stream, local_id);
    foreach (stream[j]) begin
      repeat ($urandom_range(0, 1)) begin
        i_flit = {1'b0, $urandom, $urandom, 8'($urandom)};
        @(posedge clk); #1;
      end
      send_flit(stream[j]);
    end
    drain("rand", 4000);
    check_val("rand_drop", 64'(o_drop_cnt), 64'(exp_drops));
    check_val("rand_ovf", 64'(o_overflow), 64'd0);

    // Drop counter saturation
    do_reset();
    ack_rand = 1'b0; ack_level = 1'b1;
    for (int k = 0; k < 260; k++) send_flit(mk(2'($urandom_range(1, 2)), 5'($urandom), rnd64()));
    drain("sat", 2000);
    check_val("sat_drop", 64'(o_drop_cnt), 64'd255);
    check_val("sat_ovf", 64'(o_overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
